fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline, and the block that acts on the hazard unit's stall and redirect commands. It owns the PC, drives the instruction-memory address, and selects the next PC among sequential, jump and branch targets under `addrSel`. It holds or squashes the IF/ID register as commanded and presents the fetched instruction, its PC+4 and a valid bit to decode.

---
 rtl/mips_pipe_pkg.sv | 19 +
 rtl/fetch_next_pc.sv | 36 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline fetch stage: next-PC select codes,
// the default NOP word and the IF/ID register bundle.
package mips_pipe_pkg;

  localparam logic [1:0] ADDR_SEL_PC4    = 2'b00;
  localparam logic [1:0] ADDR_SEL_JUMP   = 2'b01;
  localparam logic [1:0] ADDR_SEL_BRANCH = 2'b10;
  localparam logic [1:0] ADDR_SEL_RSVD   = 2'b11;

  // MIPS canonical NOP (sll $0,$0,0)
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: sequential PC+4, jump target formed from
// the jump held in IF/ID, or word-aligned branch target from EX.
// The reserved select code falls back to PC+4; the caller flags the error.
module fetch_next_pc
  import mips_pipe_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [3:0]  i_pc4_hi,
  input  logic [25:0] i_jump_index,
  input  logic [29:0] i_branch_hi,
  input  logic [1:0]  i_addr_sel,
  output logic [31:0] o_pc4,
  output logic [31:0] o_next_pc,
  output logic        o_rsvd
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  assign o_pc4           = i_pc + 32'd4;
  assign w_jump_target   = {i_pc4_hi, i_jump_index, 2'b00};
  assign w_branch_target = {i_branch_hi, 2'b00};

  // Next-PC mux; defaults to the sequential address
  always_comb begin
    o_next_pc = o_pc4;
    o_rsvd    = 1'b0;
    case (i_addr_sel)
      ADDR_SEL_JUMP:   o_next_pc = w_jump_target;
      ADDR_SEL_BRANCH: o_next_pc = w_branch_target;
      ADDR_SEL_RSVD:   o_rsvd    = 1'b1;
      default:         o_next_pc = o_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with the IF/ID pipeline register. Owns the PC,
// applies hazard-unit stall/flush/redirect commands and hands the fetched
// word, its PC+4 and a valid bit to decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating stall/flush
// counters; without it StallCnt/FlushCnt read as zero.
module fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        PCWrite,
  input  logic        IFWrite,
  input  logic        Flush,
  input  logic [1:0]  addrSel,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] ImemData,
  output logic [31:0] ImemAddr,
  output logic [31:0] InstrID,
  output logic [31:0] PC4ID,
  output logic        ValidID,
  output logic        AddrSelErr,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic        r_addr_sel_err;

  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_rsvd;

  fetch_next_pc u_next_pc (
    .i_pc         (r_pc),
    .i_pc4_hi     (r_ifid.pc4[31:28]),
    .i_jump_index (r_ifid.instr[25:0]),
    .i_branch_hi  (BranchTarget[31:2]),
    .i_addr_sel   (addrSel),
    .o_pc4        (w_pc4),
    .o_next_pc    (w_next_pc),
    .o_rsvd       (w_rsvd)
  );

  // PC register: advances only when the hazard unit allows it
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)     r_pc <= RESET_PC;
    else if (PCWrite) r_pc <= w_next_pc;
  end

  // IF/ID register: flush beats load; a flush keeps the old PC+4
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_ifid <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
    end else if (Flush) begin
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end else if (IFWrite) begin
      r_ifid <= '{instr: ImemData, pc4: w_pc4, valid: 1'b1};
    end
  end

  // Sticky error for the reserved select code, only when the PC is moving
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)                r_addr_sel_err <= 1'b0;
    else if (PCWrite && w_rsvd)  r_addr_sel_err <= 1'b1;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating performance counters
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!PCWrite && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (Flush && (r_flush_cnt != 32'hFFFF_FFFF))    r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

  assign ImemAddr   = r_pc;
  assign InstrID    = r_ifid.instr;
  assign PC4ID      = r_ifid.pc4;
  assign ValidID    = r_ifid.valid;
  assign AddrSelErr = r_addr_sel_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run, all compared against a behavioural fetch-stage model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b1;
  logic        PCWrite = 1'b0;
  logic        IFWrite = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  addrSel = 2'b00;
  logic [31:0] BranchTarget = 32'd0;
  logic [31:0] ImemData;
  logic [31:0] ImemAddr, InstrID, PC4ID, StallCnt, FlushCnt;
  logic        ValidID, AddrSelErr;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic        m_valid, m_err;

  fetch_unit dut (
    .CLK(CLK), .Reset_L(Reset_L), .PCWrite(PCWrite), .IFWrite(IFWrite),
    .Flush(Flush), .addrSel(addrSel), .BranchTarget(BranchTarget),
    .ImemData(ImemData), .ImemAddr(ImemAddr), .InstrID(InstrID),
    .PC4ID(PC4ID), .ValidID(ValidID), .AddrSelErr(AddrSelErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  // Instruction memory contents: a jump to 0x100 at 0xC, hashed words elsewhere
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0800_0040;
    return (a * 32'h9E37_79B1) + 32'h1234_5677;
  endfunction

  assign ImemData = imem(ImemAddr);

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    m_err = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
  endtask

  // Apply one cycle of commands and advance the model by the fetch rules
  task automatic step(input logic pcw, input logic ifw, input logic fl,
                      input logic [1:0] sel, input logic [31:0] bt);
    logic [31:0] seq, npc;
    PCWrite = pcw; IFWrite = ifw; Flush = fl; addrSel = sel; BranchTarget = bt;
    seq = m_pc + 32'd4;
    if (sel == 2'd1)      npc = {m_pc4[31:28], m_instr[25:0], 2'b00};
    else if (sel == 2'd2) npc = bt & 32'hFFFF_FFFC;
    else                  npc = seq;
    @(posedge CLK);
    if (fl) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (ifw) begin
      m_instr = imem(m_pc); m_pc4 = seq; m_valid = 1'b1;
    end
    if (pcw) begin
      if (sel == 2'd3) m_err = 1'b1;
      m_pc = npc;
    end
`ifdef FETCH_PERF_CNT_EN
    if (!pcw && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (fl && m_flush != 32'hFFFF_FFFF)   m_flush = m_flush + 1;
`endif
    #1;
  endtask

  task automatic test_reset();
    #2 Reset_L = 1'b0;
    #1;
    model_reset();
    n_vec++; if (ImemAddr !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h exp %h", ImemAddr, 32'd0); end
    n_vec++; if (InstrID !== NOP) begin n_err++; $display("FAIL reset_instr: got %h exp %h", InstrID, NOP); end
    n_vec++; if (PC4ID !== 32'd0) begin n_err++; $display("FAIL reset_pc4: got %h exp 0", PC4ID); end
    n_vec++; if (ValidID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", ValidID); end
    n_vec++; if (AddrSelErr !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", AddrSelErr); end
    n_vec++; if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %h/%h exp 0/0", StallCnt, FlushCnt); end
    @(negedge CLK);
    Reset_L = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'b00, 32'd0);
      exp_addr = 32'd4 * (i + 1);
      n_vec++; if (ImemAddr !== exp_addr) begin n_err++; $display("FAIL seq_addr%0d: got %h exp %h", i, ImemAddr, exp_addr); end
      n_vec++; if (PC4ID !== exp_addr || ValidID !== 1'b1) begin n_err++; $display("FAIL seq_ifid%0d: got %h/%b exp %h/1", i, PC4ID, ValidID, exp_addr); end
      n_vec++; if (InstrID !== m_instr) begin n_err++; $display("FAIL seq_instr%0d: got %h exp %h", i, InstrID, m_instr); end
    end
  endtask

  task automatic test_jump();
    n_vec++; if (InstrID !== 32'h0800_0040 || PC4ID !== 32'h10) begin n_err++; $display("FAIL jump_setup: got %h/%h exp 08000040/00000010", InstrID, PC4ID); end
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'd0);
    n_vec++; if (ImemAddr !== 32'h100) begin n_err++; $display("FAIL jump_addr: got %h exp 00000100", ImemAddr); end
    n_vec++; if (InstrID !== 32'h0800_0040) begin n_err++; $display("FAIL jump_hold: got %h exp 08000040", InstrID); end
    step(1'b1, 1'b1, 1'b0, 2'b00, 32'd0);
    n_vec++; if (InstrID !== imem(32'h100) || PC4ID !== 32'h104) begin n_err++; $display("FAIL jump_target: got %h/%h exp %h/00000104", InstrID, PC4ID, imem(32'h100)); end
  endtask

  task automatic test_stall();
    logic [31:0] a, ins, p4;
    a = ImemAddr; ins = InstrID; p4 = PC4ID;
    step(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
    n_vec++; if (ImemAddr !== a || InstrID !== ins || PC4ID !== p4) begin n_err++; $display("FAIL stall_hold: got %h/%h/%h exp %h/%h/%h", ImemAddr, InstrID, PC4ID, a, ins, p4); end
    n_vec++; if (StallCnt !== m_stall) begin n_err++; $display("FAIL stall_cnt: got %h exp %h", StallCnt, m_stall); end
    n_vec++; if (AddrSelErr !== 1'b0) begin n_err++; $display("FAIL stall_err: got %b exp 0", AddrSelErr); end
  endtask

  task automatic test_branch_flush();
    step(1'b1, 1'b1, 1'b1, 2'b10, 32'h0000_0203);
    n_vec++; if (ImemAddr !== 32'h200) begin n_err++; $display("FAIL branch_addr: got %h exp 00000200", ImemAddr); end
    n_vec++; if (ValidID !== 1'b0 || InstrID !== NOP) begin n_err++; $display("FAIL branch_flush: got %h/%b exp %h/0", InstrID, ValidID, NOP); end
    n_vec++; if (PC4ID !== m_pc4) begin n_err++; $display("FAIL branch_pc4: got %h exp %h", PC4ID, m_pc4); end
    n_vec++; if (FlushCnt !== m_flush) begin n_err++; $display("FAIL branch_fcnt: got %h exp %h", FlushCnt, m_flush); end
  endtask

  task automatic test_wrap_and_err();
    step(1'b1, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE);
    n_vec++; if (ImemAddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup: got %h exp fffffffc", ImemAddr); end
    step(1'b1, 1'b1, 1'b0, 2'b00, 32'd0);
    n_vec++; if (ImemAddr !== 32'd0 || PC4ID !== 32'd0) begin n_err++; $display("FAIL wrap_addr: got %h/%h exp 0/0", ImemAddr, PC4ID); end
    step(1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0800);
    n_vec++; if (AddrSelErr !== 1'b1 || ImemAddr !== 32'd4) begin n_err++; $display("FAIL rsvd_sel: got %b/%h exp 1/00000004", AddrSelErr, ImemAddr); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'b00, 32'd0);
      n_vec++; if (AddrSelErr !== 1'b1) begin n_err++; $display("FAIL err_sticky%0d: got %b exp 1", i, AddrSelErr); end
    end
  endtask

  task automatic test_random();
    logic [31:0] bt;
    for (int i = 0; i < 300; i++) begin
      bt = $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), bt);
      n_vec++;
      if (ImemAddr !== m_pc || InstrID !== m_instr || PC4ID !== m_pc4 || ValidID !== m_valid ||
          AddrSelErr !== m_err || StallCnt !== m_stall || FlushCnt !== m_flush) begin
        n_err++;
        $display("FAIL rand%0d: got pc=%h ins=%h p4=%h v=%b e=%b s=%h f=%h exp pc=%h ins=%h p4=%h v=%b e=%b s=%h f=%h",
                 i, ImemAddr, InstrID, PC4ID, ValidID, AddrSelErr, StallCnt, FlushCnt,
                 m_pc, m_instr, m_pc4, m_valid, m_err, m_stall, m_flush);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    step(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0404);
    PCWrite = 1'b0; IFWrite = 1'b0; addrSel = 2'b01;
    #1 Reset_L = 1'b0;
    #1;
    model_reset();
    n_vec++; if (ImemAddr !== 32'd0 || InstrID !== NOP || PC4ID !== 32'd0 || ValidID !== 1'b0) begin n_err++; $display("FAIL midreset_ifid: got %h/%h/%h/%b exp 0/%h/0/0", ImemAddr, InstrID, PC4ID, ValidID, NOP); end
    n_vec++; if (AddrSelErr !== 1'b0 || StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin n_err++; $display("FAIL midreset_flags: got %b/%h/%h exp 0/0/0", AddrSelErr, StallCnt, FlushCnt); end
    @(posedge CLK); #1;
    n_vec++; if (ImemAddr !== 32'd0) begin n_err++; $display("FAIL midreset_hold: got %h exp 0", ImemAddr); end
    @(negedge CLK);
    Reset_L = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2'b00, 32'd0);
    n_vec++; if (ImemAddr !== 32'd4 || InstrID !== imem(32'd0) || ValidID !== 1'b1) begin n_err++; $display("FAIL postreset_fetch: got %h/%h/%b exp 00000004/%h/1", ImemAddr, InstrID, ValidID, imem(32'd0)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_branch_flush();
    test_wrap_and_err();
    test_random();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
